// File: rtl/dac_pkg.sv
// Shared constants and types for the PWM DAC that follows the FM NCO.
package dac_pkg;

  localparam int SINE_WIDTH_DEFAULT = 8;
  localparam int PWM_MAX = (1 << SINE_WIDTH_DEFAULT) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  // Last counter value of a PWM period for a given counter width.
  function automatic int period_last(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM engine: free-running period counter, duty compare, period-start pulse
// and wrap detect. The parent decides when a period begins and which duty is active.
module pwm_core
  import dac_pkg::*;
#(
  parameter int SINE_WIDTH = SINE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  run,
  input  logic                  start,
  input  logic [SINE_WIDTH-1:0] duty,
  output logic                  wrap,
  output logic                  pwm_out,
  output logic                  period_start
);

  localparam logic [SINE_WIDTH-1:0] CNT_MAX = SINE_WIDTH'(period_last(SINE_WIDTH));

  logic [SINE_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pwm_q, pwm_d;
  logic                  period_start_q, period_start_d;

  assign wrap         = (cnt_q == CNT_MAX);
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

  // Advance the counter and compare on enabled cycles; everything holds otherwise.
  always_comb begin
    cnt_d          = cnt_q;
    pwm_d          = pwm_q;
    period_start_d = period_start_q;
    if (enable) begin
      if (run) begin
        pwm_d          = (cnt_q < duty);
        cnt_d          = cnt_q + 1'b1;
        period_start_d = wrap;
      end else if (start) begin
        cnt_d          = '0;
        pwm_d          = 1'b0;
        period_start_d = 1'b1;
      end
    end
  end

  // Counter, output and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC top: one-entry shadow buffer with valid/ready, IDLE/RUN control,
// period-boundary duty commit and sticky underrun flag around pwm_core.
module pwm_dac
  import dac_pkg::*;
#(
  parameter int SINE_WIDTH = SINE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [SINE_WIDTH-1:0] sample,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  underrun_clr,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  underrun
);

  pwm_state_t            state_q, state_d;
  logic [SINE_WIDTH-1:0] duty_q, duty_d;
  logic [SINE_WIDTH-1:0] shadow_q, shadow_d;
  logic                  shadow_full_q, shadow_full_d;
  logic                  underrun_q, underrun_d;

  logic accept;
  logic start;
  logic boundary;
  logic commit;
  logic wrap;

  assign sample_ready = !shadow_full_q;
  assign underrun     = underrun_q;

  // Decode handshake, first-period start and end-of-period events.
  always_comb begin
    accept   = sample_valid && !shadow_full_q;
    start    = enable && (state_q == IDLE) && shadow_full_q;
    boundary = enable && (state_q == RUN) && wrap;
    commit   = start || (boundary && shadow_full_q);
  end

  // Next state for FSM, duty, shadow buffer and underrun flag.
  always_comb begin
    state_d       = state_q;
    duty_d        = duty_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    underrun_d    = underrun_q;

    if (start) begin
      state_d = RUN;
    end

    if (commit) begin
      duty_d        = shadow_q;
      shadow_full_d = 1'b0;
    end else if (accept) begin
      shadow_d      = sample;
      shadow_full_d = 1'b1;
    end

    if (boundary && !shadow_full_q) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // Control and buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      duty_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      underrun_q    <= underrun_d;
    end
  end

  pwm_core #(
    .SINE_WIDTH(SINE_WIDTH)
  ) u_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .run         (state_q == RUN),
    .start       (start),
    .duty        (duty_q),
    .wrap        (wrap),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: directed scenarios plus a randomized run,
// all checked against a behavioural model of period position, duty and buffer.
module tb_pwm_dac;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       underrun_clr;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_active, m_full, m_under, exp_pwm, exp_ps;
  int m_pos, m_duty, m_val;

  always #5 clk = ~clk;

  pwm_dac #(.SINE_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .underrun_clr(underrun_clr),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .underrun    (underrun)
  );

  task automatic model_reset();
    m_active = 0; m_full = 0; m_under = 0; exp_pwm = 0; exp_ps = 0;
    m_pos = 0; m_duty = 0; m_val = 0;
  endtask

  // One clock: the model applies the rules to the inputs in force at this edge.
  task automatic tick();
    bit pre_full, acc, set_u;
    pre_full = m_full;
    acc      = (sample_valid === 1'b1) && !pre_full;
    set_u    = 0;
    if (enable) begin
      if (!m_active) begin
        if (pre_full) begin
          m_duty = m_val; m_full = 0; m_active = 1; m_pos = 0;
          exp_ps = 1; exp_pwm = 0;
        end
      end else begin
        exp_pwm = (m_pos < m_duty);
        exp_ps  = (m_pos == 255);
        if (m_pos == 255) begin
          if (pre_full) begin m_duty = m_val; m_full = 0; end
          else set_u = 1;
        end
        m_pos = (m_pos + 1) % 256;
      end
    end
    if (set_u) m_under = 1;
    else if (underrun_clr) m_under = 0;
    if (acc) begin m_full = 1; m_val = sample; end
    @(posedge clk); #1;
  endtask

  // Runs n enabled cycles, optionally offering a sample at index send_at and
  // inserting gap_len disabled cycles before index gap_at. Returns high count
  // and number of cycles where outputs disagreed with the model.
  task automatic run_period(input int n, input int send_at, input logic [7:0] send_val,
                            input bit hold, input int gap_at, input int gap_len,
                            output int highs, output int errs);
    highs = 0; errs = 0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          enable = 1'b0;
          if (k == send_at && g == 0) begin sample = send_val; sample_valid = 1'b1; end
          else if (!hold) sample_valid = 1'b0;
          tick();
          if ({pwm_out, period_start, sample_ready, underrun} !== {exp_pwm, exp_ps, ~m_full, m_under}) errs++;
        end
      end
      enable = 1'b1;
      if (k == send_at && k != gap_at) begin sample = send_val; sample_valid = 1'b1; end
      else if (!hold) sample_valid = 1'b0;
      tick();
      if (pwm_out === 1'b1) highs++;
      if ({pwm_out, period_start, sample_ready, underrun} !== {exp_pwm, exp_ps, ~m_full, m_under}) errs++;
    end
    if (!hold) sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; sample = '0; sample_valid = 1'b0; underrun_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_out); end
    n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ps: got %b expected 0", period_start); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", sample_ready); end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_single_sample();
    int highs, errs;
    enable = 1'b0; sample = 8'd64; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 0", sample_ready); end
    enable = 1'b1;
    tick();
    n_tests++; if (period_start !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ps: got %b expected 1", period_start); end
    run_period(256, -1, 8'd0, 0, -1, 0, highs, errs);
    n_tests++; if (highs != 64) begin n_fail++; $display("[TB] FAIL single_highs: got %0d expected 64", highs); end
    n_tests++; if (errs != 0) begin n_fail++; $display("[TB] FAIL single_pattern: %0d cycle mismatches, expected 0", errs); end
    n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("[TB] FAIL single_underrun: got %b expected 1", underrun); end
  endtask

  task automatic test_underrun_clear();
    int highs, errs;
    run_period(255, -1, 8'd0, 0, -1, 0, highs, errs);
    n_tests++; if (errs != 0) begin n_fail++; $display("[TB] FAIL uclr_pattern: %0d cycle mismatches, expected 0", errs); end
    enable = 1'b1; underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("[TB] FAIL uclr_set_wins: got %b expected 1", underrun); end
    enable = 1'b0; underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0; enable = 1'b1;
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL uclr_clear: got %b expected 0", underrun); end
  endtask

  task automatic test_boundary_duty();
    int highs, errs;
    enable = 1'b0; sample = 8'd0; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    run_period(256, -1, 8'd0, 0, -1, 0, highs, errs);
    n_tests++; if (highs != 64) begin n_fail++; $display("[TB] FAIL bnd_prev_highs: got %0d expected 64", highs); end
    run_period(256, 3, 8'd255, 0, -1, 0, highs, errs);
    n_tests++; if (highs != 0) begin n_fail++; $display("[TB] FAIL bnd_zero_highs: got %0d expected 0", highs); end
    n_tests++; if (errs != 0) begin n_fail++; $display("[TB] FAIL bnd_zero_pattern: %0d cycle mismatches, expected 0", errs); end
    run_period(256, 3, 8'd32, 0, -1, 0, highs, errs);
    n_tests++; if (highs != 255) begin n_fail++; $display("[TB] FAIL bnd_max_highs: got %0d expected 255", highs); end
    n_tests++; if (errs != 0) begin n_fail++; $display("[TB] FAIL bnd_max_pattern: %0d cycle mismatches, expected 0", errs); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL bnd_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_mid_period_update();
    int h1, h2, e1, e2;
    run_period(11, 10, 8'd128, 0, -1, 0, h1, e1);
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_ready: got %b expected 0", sample_ready); end
    run_period(245, -1, 8'd0, 0, -1, 0, h2, e2);
    n_tests++; if (h1 + h2 != 32) begin n_fail++; $display("[TB] FAIL mid_cur_highs: got %0d expected 32", h1 + h2); end
    n_tests++; if (e1 + e2 != 0) begin n_fail++; $display("[TB] FAIL mid_pattern: %0d cycle mismatches, expected 0", e1 + e2); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ready_after: got %b expected 1", sample_ready); end
  endtask

  task automatic test_backpressure();
    int h1, h2, e1, e2;
    run_period(20, 5, 8'd150, 0, -1, 0, h1, e1);
    run_period(236, 0, 8'd200, 1, -1, 0, h2, e2);
    n_tests++; if (h1 + h2 != 128) begin n_fail++; $display("[TB] FAIL bp_next_highs: got %0d expected 128", h1 + h2); end
    n_tests++; if (e1 + e2 != 0) begin n_fail++; $display("[TB] FAIL bp_hold_pattern: %0d cycle mismatches, expected 0", e1 + e2); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_after_commit: got %b expected 1", sample_ready); end
    run_period(1, 0, 8'd200, 0, -1, 0, h1, e1);
    n_tests++; if (sample_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_consumed: got ready %b expected 0", sample_ready); end
    run_period(255, -1, 8'd0, 0, -1, 0, h2, e2);
    n_tests++; if (h1 + h2 != 150) begin n_fail++; $display("[TB] FAIL bp_no_overwrite_highs: got %0d expected 150", h1 + h2); end
    run_period(256, 5, 8'd100, 0, -1, 0, h1, e1);
    n_tests++; if (h1 != 200) begin n_fail++; $display("[TB] FAIL bp_held_highs: got %0d expected 200", h1); end
    n_tests++; if (e1 + e2 != 0) begin n_fail++; $display("[TB] FAIL bp_pattern: %0d cycle mismatches, expected 0", e1 + e2); end
  endtask

  task automatic test_enable_gap();
    int highs, errs;
    run_period(256, 40, 8'd77, 0, 40, 17, highs, errs);
    n_tests++; if (highs != 100) begin n_fail++; $display("[TB] FAIL gap_highs: got %0d expected 100", highs); end
    n_tests++; if (errs != 0) begin n_fail++; $display("[TB] FAIL gap_pattern: %0d cycle mismatches, expected 0", errs); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_accept: underrun %b expected 0", underrun); end
  endtask

  task automatic test_reset_mid_period();
    int highs, errs;
    run_period(50, 10, 8'd9, 0, -1, 0, highs, errs);
    n_tests++; if (pwm_out !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_pre_pwm: got %b expected 1", pwm_out); end
    reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_pwm: got %b expected 0", pwm_out); end
    n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_ready: got %b expected 1", sample_ready); end
    #2 reset_n = 1'b1;
    errs = 0;
    enable = 1'b1; sample_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (period_start !== 1'b0 || pwm_out !== 1'b0) errs++;
    end
    n_tests++; if (errs != 0) begin n_fail++; $display("[TB] FAIL rmid_idle: %0d cycles with activity, expected 0", errs); end
    sample = 8'd10; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_no_early_ps: got %b expected 0", period_start); end
    tick();
    n_tests++; if (period_start !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_restart_ps: got %b expected 1", period_start); end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int i = 0; i < 4000; i++) begin
      enable       = ($urandom_range(0, 9) != 0);
      sample_valid = ($urandom_range(0, 3) == 0);
      sample       = 8'($urandom);
      underrun_clr = ($urandom_range(0, 19) == 0);
      tick();
      n_tests++;
      if ({pwm_out, period_start, sample_ready, underrun} !== {exp_pwm, exp_ps, ~m_full, m_under}) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("[TB] FAIL random_cycle %0d: got pwm/ps/rdy/ur=%b%b%b%b expected %b%b%b%b",
                   i, pwm_out, period_start, sample_ready, underrun, exp_pwm, exp_ps, ~m_full, m_under);
        end
      end
    end
    sample_valid = 1'b0; underrun_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_underrun_clear();
    test_boundary_duty();
    test_mid_period_update();
    test_backpressure();
    test_enable_gap();
    test_reset_mid_period();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
